// File: rtl/sys_input_conditioner.sv
// -----------------------------------------------------------------------------
// sys_input_conditioner
//
// Inbound half of the board interface. Turns the raw DE2 push-buttons
// (active-low, bouncy) and slide switches (asynchronous) into clean signals
// in the SYS_clk_in domain for the system core.
//
// Ports
//   SYS_clk_in   in   1         system clock, rising edge
//   SYS_rst      in   1         asynchronous reset, active-high
//   KEY_n        in   NUM_KEYS  raw push-buttons, 0 = pressed
//   SW_raw       in   NUM_SW    raw slide switches
//   key_level    out  NUM_KEYS  debounced key state, 1 = pressed
//   key_press    out  NUM_KEYS  one-cycle pulse on committed press
//   key_release  out  NUM_KEYS  one-cycle pulse on committed release
//   step_pulse   out  1         key_press[STEP_KEY], drives single-step
//   sw_sync      out  NUM_SW    synchronized switch values
//   sw_changed   out  1         one-cycle strobe when any sw_sync bit moves
//
// Per-key debounce FSM
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   S_UP       | key committed released, waiting for a press sample
//   S_WAIT_DN  | press seen, counting stable pressed samples
//   S_DN       | key committed pressed, waiting for a release sample
//   S_WAIT_UP  | release seen, counting stable released samples
// -----------------------------------------------------------------------------
module sys_input_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int NUM_SW          = 18,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int STEP_KEY        = 0
) (
    input  logic                SYS_clk_in,
    input  logic                SYS_rst,
    input  logic [NUM_KEYS-1:0] KEY_n,
    input  logic [NUM_SW-1:0]   SW_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                step_pulse,
    output logic [NUM_SW-1:0]   sw_sync,
    output logic                sw_changed
);

    typedef enum logic [1:0] {
        S_UP      = 2'd0,
        S_WAIT_DN = 2'd1,
        S_DN      = 2'd2,
        S_WAIT_UP = 2'd3
    } key_state_t;

    // The debounce timer is a down-counter. Entering a wait state already
    // accounts for the first stable sample, so it loads DEBOUNCE_CYCLES-2 and
    // commits on the sample where it reads zero: DEBOUNCE_CYCLES consecutive
    // stable samples in total. It is never decremented at zero, so no wrap.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Key synchronizers (reset to released = 1)
    // ------------------------------------------------------------------
    logic [NUM_KEYS-1:0] key_meta;
    logic [NUM_KEYS-1:0] key_sync;
    logic [NUM_KEYS-1:0] k_s;

    always_ff @(posedge SYS_clk_in or posedge SYS_rst) begin
        if (SYS_rst) begin
            key_meta <= '1;
            key_sync <= '1;
        end else begin
            key_meta <= KEY_n;
            key_sync <= key_meta;
        end
    end

    assign k_s = ~key_sync;

    // ------------------------------------------------------------------
    // Independent debounce FSM per key
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_state_t       state;
        key_state_t       state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             level_q;
        logic             level_nxt;
        logic             press_q;
        logic             press_nxt;
        logic             release_q;
        logic             release_nxt;

        always_ff @(posedge SYS_clk_in or posedge SYS_rst) begin
            if (SYS_rst) begin
                state     <= S_UP;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
            end
        end

        always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt;
            level_nxt   = level_q;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;

            case (state)
                S_UP: begin
                    level_nxt = 1'b0;
                    if (k_s[g]) begin
                        state_nxt = S_WAIT_DN;
                        cnt_nxt   = CNT_LOAD;
                    end
                end

                S_WAIT_DN: begin
                    if (!k_s[g]) begin
                        state_nxt = S_UP;
                        cnt_nxt   = '0;
                    end else if (cnt == '0) begin
                        state_nxt = S_DN;
                        level_nxt = 1'b1;
                        press_nxt = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end

                S_DN: begin
                    level_nxt = 1'b1;
                    if (!k_s[g]) begin
                        state_nxt = S_WAIT_UP;
                        cnt_nxt   = CNT_LOAD;
                    end
                end

                S_WAIT_UP: begin
                    if (k_s[g]) begin
                        state_nxt = S_DN;
                        cnt_nxt   = '0;
                    end else if (cnt == '0) begin
                        state_nxt   = S_UP;
                        level_nxt   = 1'b0;
                        release_nxt = 1'b1;
                        cnt_nxt     = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end

                default: begin
                    state_nxt = S_UP;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                end
            endcase
        end

        assign key_level[g]   = level_q;
        assign key_press[g]   = press_q;
        assign key_release[g] = release_q;
    end

    assign step_pulse = key_press[STEP_KEY];

    // ------------------------------------------------------------------
    // Switch synchronizers and change strobe
    // ------------------------------------------------------------------
    logic [NUM_SW-1:0] sw_meta;
    logic [NUM_SW-1:0] sw_sync_q;
    logic [NUM_SW-1:0] sw_prev;
    logic [1:0]        primed_cnt;
    logic              primed;

    always_ff @(posedge SYS_clk_in or posedge SYS_rst) begin
        if (SYS_rst) begin
            sw_meta    <= '0;
            sw_sync_q  <= '0;
            sw_prev    <= '0;
            primed_cnt <= 2'd0;
        end else begin
            sw_meta   <= SW_raw;
            sw_sync_q <= sw_meta;
            sw_prev   <= sw_sync_q;
            if (primed_cnt != 2'd3) begin
                primed_cnt <= primed_cnt + 2'd1;
            end
        end
    end

    // The synchronizer leaves reset at zero, so switches already set at
    // power-up would look like a change on the 2nd edge. Masking until the
    // 3rd edge, by which point sw_prev holds real switch values, hides that.
    assign primed     = (primed_cnt == 2'd3);
    assign sw_sync    = sw_sync_q;
    assign sw_changed = primed && (sw_sync_q != sw_prev);

endmodule

// File: tb/tb_sys_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_sys_input_conditioner
//
// Self-checking bench for sys_input_conditioner with DEBOUNCE_CYCLES = 4.
// A behavioural model (two-sample input delay, then "D consecutive samples
// that disagree with the committed level flip it") predicts every output on
// every cycle; directed scenarios add pulse-count and pulse-timing checks,
// followed by a randomized phase with occasional asynchronous resets.
// -----------------------------------------------------------------------------
module tb_sys_input_conditioner;

    localparam int NK = 4;
    localparam int NS = 18;
    localparam int D  = 4;
    localparam int CW = 20;
    localparam int SK = 0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key_n = '1;
    logic [NS-1:0] sw_raw = '0;

    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          step_pulse;
    logic [NS-1:0] sw_sync;
    logic          sw_changed;

    always #5 clk = ~clk;

    sys_input_conditioner #(
        .NUM_KEYS        (NK),
        .NUM_SW          (NS),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW),
        .STEP_KEY        (SK)
    ) dut (
        .SYS_clk_in  (clk),
        .SYS_rst     (rst),
        .KEY_n       (key_n),
        .SW_raw      (sw_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .step_pulse  (step_pulse),
        .sw_sync     (sw_sync),
        .sw_changed  (sw_changed)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [NK-1:0] m_k1, m_k2;
    logic [NK-1:0] m_lvl, m_press, m_rel;
    int            m_run [NK];
    logic [NS-1:0] m_w1, m_w2;
    int            m_edges;
    logic          m_chg;

    function automatic void model_reset();
        m_k1    = '1;
        m_k2    = '1;
        m_lvl   = '0;
        m_press = '0;
        m_rel   = '0;
        for (int k = 0; k < NK; k++) m_run[k] = 0;
        m_w1    = '0;
        m_w2    = '0;
        m_edges = 0;
        m_chg   = 1'b0;
    endfunction

    function automatic void model_edge();
        logic [NS-1:0] old_w;
        logic          seen;
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < NK; k++) begin
                seen       = ~m_k2[k];
                m_press[k] = 1'b0;
                m_rel[k]   = 1'b0;
                if (seen != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == D) begin
                        m_lvl[k] = seen;
                        if (seen) m_press[k] = 1'b1;
                        else      m_rel[k]   = 1'b1;
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_k2 = m_k1;
            m_k1 = key_n;
            old_w = m_w2;
            m_w2  = m_w1;
            m_w1  = sw_raw;
            if (m_edges < 3) m_edges++;
            m_chg = (m_edges >= 3) && (m_w2 != old_w);
        end
    endfunction

    // ---------------- per-scenario statistics ----------------
    int            cyc;
    int            press_cnt [NK];
    int            rel_cnt [NK];
    int            first_press [NK];
    int            first_rel [NK];
    int            chg_cnt;
    int            first_chg;
    int            step_cnt;
    logic [NK-1:0] first_vec;

    function automatic void clr_stats();
        cyc = 0;
        for (int k = 0; k < NK; k++) begin
            press_cnt[k]   = 0;
            rel_cnt[k]     = 0;
            first_press[k] = 0;
            first_rel[k]   = 0;
        end
        chg_cnt   = 0;
        first_chg = 0;
        step_cnt  = 0;
        first_vec = '0;
    endfunction

    // One clock: drive inputs, let the edge happen, update model, compare.
    task automatic step(input logic [NK-1:0] kn, input logic [NS-1:0] sw);
        key_n  = kn;
        sw_raw = sw;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        chk("key_level",   32'(key_level),   32'(m_lvl));
        chk("key_press",   32'(key_press),   32'(m_press));
        chk("key_release", 32'(key_release), 32'(m_rel));
        chk("step_pulse",  32'(step_pulse),  32'(m_press[SK]));
        chk("sw_sync",     32'(sw_sync),     32'(m_w2));
        chk("sw_changed",  32'(sw_changed),  32'(m_chg));
        for (int k = 0; k < NK; k++) begin
            if (key_press[k] === 1'b1) begin
                press_cnt[k]++;
                if (first_press[k] == 0) first_press[k] = cyc;
            end
            if (key_release[k] === 1'b1) begin
                rel_cnt[k]++;
                if (first_rel[k] == 0) first_rel[k] = cyc;
            end
        end
        if (key_press != '0 && first_vec == '0) first_vec = key_press;
        if (step_pulse === 1'b1) step_cnt++;
        if (sw_changed === 1'b1) begin
            chg_cnt++;
            if (first_chg == 0) first_chg = cyc;
        end
    endtask

    task automatic repeat_step(input int n, input logic [NK-1:0] kn, input logic [NS-1:0] sw);
        for (int i = 0; i < n; i++) step(kn, sw);
    endtask

    // Assert reset between edges, confirm outputs clear at once, hold it for
    // two edges. The caller releases rst afterwards (still between edges).
    task automatic async_reset();
        #3;
        rst = 1'b1;
        #1;
        chk("rst_key_level",   32'(key_level),   32'h0);
        chk("rst_key_press",   32'(key_press),   32'h0);
        chk("rst_key_release", 32'(key_release), 32'h0);
        chk("rst_step_pulse",  32'(step_pulse),  32'h0);
        chk("rst_sw_sync",     32'(sw_sync),     32'h0);
        chk("rst_sw_changed",  32'(sw_changed),  32'h0);
        model_reset();
        repeat_step(2, key_n, sw_raw);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [NK-1:0] kn;
        logic [NS-1:0] sw;
        int            idx;

        model_reset();
        clr_stats();

        // Power-up with switches already set.
        repeat_step(3, 4'hF, 18'h00005);
        rst = 1'b0;
        clr_stats();
        repeat_step(10, 4'hF, 18'h00005);
        chk("pwr_sw_sync", 32'(sw_sync), 32'h5);
        chk("pwr_no_chg",  32'(chg_cnt), 32'd0);

        // Key 0 press / hold / release.
        clr_stats();
        repeat_step(26, 4'b1110, 18'h00005);
        repeat_step(12, 4'b1111, 18'h00005);
        chk("k0_press_edge",   32'(first_press[0]), 32'd6);
        chk("k0_press_count",  32'(press_cnt[0]),   32'd1);
        chk("k0_rel_edge",     32'(first_rel[0]),   32'd32);
        chk("k0_rel_count",    32'(rel_cnt[0]),     32'd1);
        chk("k0_step_count",   32'(step_cnt),       32'd1);

        // Key 1: 3-cycle glitch rejected, 5-cycle press accepted.
        clr_stats();
        repeat_step(3, 4'b1101, 18'h00005);
        repeat_step(10, 4'b1111, 18'h00005);
        chk("k1_glitch_press", 32'(press_cnt[1]), 32'd0);
        chk("k1_glitch_level", 32'(key_level[1]), 32'd0);
        repeat_step(5, 4'b1101, 18'h00005);
        repeat_step(12, 4'b1111, 18'h00005);
        chk("k1_press_count",  32'(press_cnt[1]), 32'd1);
        chk("k1_rel_count",    32'(rel_cnt[1]),   32'd1);

        // Key 2: bounce train then settle low.
        clr_stats();
        for (int i = 1; i <= 10; i++) step((i % 2 == 0) ? 4'b1111 : 4'b1011, 18'h00005);
        repeat_step(12, 4'b1011, 18'h00005);
        chk("k2_press_count", 32'(press_cnt[2]),   32'd1);
        chk("k2_press_edge",  32'(first_press[2]), 32'd16);
        repeat_step(12, 4'b1111, 18'h00005);

        // Keys 0 and 3 together.
        clr_stats();
        repeat_step(10, 4'b0110, 18'h00005);
        chk("k03_press_vec",  32'(first_vec),      32'h9);
        chk("k03_press_edge", 32'(first_press[3]), 32'd6);
        chk("k03_step_count", 32'(step_cnt),       32'd1);
        repeat_step(12, 4'b1111, 18'h00005);

        // Switch 9 toggle.
        clr_stats();
        repeat_step(6, 4'b1111, 18'h00205);
        chk("sw9_chg_count", 32'(chg_cnt),   32'd1);
        chk("sw9_chg_edge",  32'(first_chg), 32'd2);

        // Reset in the middle of a key-0 debounce.
        clr_stats();
        repeat_step(3, 4'b1110, 18'h00205);
        async_reset();
        chk("midrst_no_press", 32'(press_cnt[0]), 32'd0);
        rst = 1'b0;
        clr_stats();
        repeat_step(10, 4'b1110, 18'h00205);
        chk("midrst_press_edge",  32'(first_press[0]), 32'd6);
        chk("midrst_press_count", 32'(press_cnt[0]),   32'd1);
        repeat_step(12, 4'b1111, 18'h00205);

        // Randomized phase.
        kn = 4'hF;
        sw = 18'h00205;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NK; k++) begin
                if ($urandom_range(0, 7) == 0) kn[k] = ~kn[k];
            end
            if ($urandom_range(0, 15) == 0) begin
                idx = int'($urandom_range(0, NS - 1));
                sw[idx] = ~sw[idx];
            end
            step(kn, sw);
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
                rst = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
